// File: rtl/ts_efa_pkg.sv
// Shared types and constants for the exponential-approximator scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ts_efa_pkg;

  // Default approximator index width (scaling + template LUT address bits)
  localparam int T_FIX_WID = 16;
  // Register stages inside the approximator from t_fix_reg to its output
  localparam int EFA_LAT   = 3;
  // Tag id field sized for the largest supported requester count (8)
  localparam int ID_WID    = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ID_WID-1:0] id;
  } tag_t;

endpackage

// File: rtl/ts_efa_rr_arb.sv
// Requester arbiter: one-hot grant plus encoded id, gated by en.
// Latency: combinational grant; pointer (if any) updates on the grant edge.
// Backpressure: en low forces no grant and freezes the pointer.
// Build option: TS_EFA_SCHED_RR_EN selects round-robin, otherwise fixed priority.
module ts_efa_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
`ifdef TS_EFA_SCHED_RR_EN
  input  logic             clk,
  input  logic             reset_n,
`endif
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   id
);

  // Index where the priority search begins
  logic [IDW-1:0] base;

`ifdef TS_EFA_SCHED_RR_EN
  logic [IDW-1:0] ptr;

  assign base = ptr;

  // Priority restarts just past the most recently granted requester
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;
    end
  end
`else
  assign base = '0;
`endif

  int             s;
  logic [IDW-1:0] idx;
  logic           found;

  // Scan requesters starting at base, wrapping once around the vector
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    s     = 0;
    idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      idx = IDW'(s);
      if (!found && req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
    if (en && found) gnt[id] = 1'b1;
  end

endmodule

// File: rtl/ts_efa_sched.sv
// Shares one exponential approximator among N_REQ requesters, one lookup per cycle, id-tagged results.
// Latency: grant in cycle k, efa_t_fix in k+1, rsp_valid/rsp_id/rsp_val in k+5.
// Backpressure: req held until gnt; halt_req blocks grants, drains in-flight lookups, then raises halt_ack.
// Build option: TS_EFA_SCHED_RR_EN enables round-robin arbitration (fixed priority otherwise).
module ts_efa_sched
  import ts_efa_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int SCAL_ADDR_LEN = 8,
  parameter int TEMP_ADDR_LEN = 8,
  parameter int DT_WID        = 20
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [N_REQ-1:0]                       req,
  input  logic [N_REQ*DT_WID-1:0]                dt,
  output logic [N_REQ-1:0]                       gnt,
  input  logic                                   halt_req,
  output logic                                   halt_ack,
  output logic [SCAL_ADDR_LEN+TEMP_ADDR_LEN-1:0] efa_t_fix,
  output logic                                   efa_out_en,
  input  logic [SCAL_ADDR_LEN+TEMP_ADDR_LEN-1:0] efa_val,
  output logic                                   rsp_valid,
  output logic [$clog2(N_REQ)-1:0]               rsp_id,
  output logic [SCAL_ADDR_LEN+TEMP_ADDR_LEN-1:0] rsp_val,
  output logic                                   busy
);

  localparam int TFW = SCAL_ADDR_LEN + TEMP_ADDR_LEN;
  localparam int IDW = $clog2(N_REQ);

  state_t             state;
  state_t             state_nxt;
  logic               grant_en;
  logic               any_gnt;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IDW-1:0]     arb_id;
  logic [DT_WID-1:0]  dt_sel;
  logic [TFW-1:0]     dt_sat;
  logic               pipe_busy;

  // tag_q[0] travels with efa_t_fix; tag_q[1..EFA_LAT] shadow the approximator stages,
  // so tag_q[EFA_LAT] is valid exactly when the approximator output holds a result.
  tag_t tag_q [EFA_LAT+1];

  // Grants only in RUN, and a halt request seen this cycle already blocks them
  assign grant_en = reset_n && (state == ST_RUN) && !halt_req;

  ts_efa_rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
`ifdef TS_EFA_SCHED_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .en      (grant_en),
    .req     (req),
    .gnt     (arb_gnt),
    .id      (arb_id)
  );

  assign gnt     = arb_gnt;
  assign any_gnt = |arb_gnt;

  // Select the granted requester's time difference and clamp it to the LUT range
  always_comb begin
    dt_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_id == IDW'(i)) dt_sel = dt[i*DT_WID +: DT_WID];
    end
    dt_sat = ((dt_sel >> TFW) != '0) ? '1 : dt_sel[TFW-1:0];
  end

  // Any lookup still travelling toward the response register
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i <= EFA_LAT; i++) pipe_busy = pipe_busy | tag_q[i].valid;
  end

  // Halt handshake: stop issuing, wait for the tags to clear, then acknowledge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (halt_req) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!halt_req)      state_nxt = ST_RUN;
        else if (!pipe_busy) state_nxt = ST_HALTED;
      end
      ST_HALTED: if (!halt_req) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Scheduler state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Issued lookup index; holds when idle since its tag is invalid anyway
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     efa_t_fix <= '0;
    else if (any_gnt) efa_t_fix <= dt_sat;
  end

  // Tag shift register; reset wipes in-flight lookups so they never respond
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= EFA_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].valid <= any_gnt;
      tag_q[0].id    <= ID_WID'(arb_id);
      for (int i = 1; i <= EFA_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign efa_out_en = tag_q[EFA_LAT].valid;

  // Capture the approximator result with its requester id as a one-cycle strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_val   <= '0;
    end else if (tag_q[EFA_LAT].valid) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_q[EFA_LAT].id[IDW-1:0];
      rsp_val   <= efa_val;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  assign halt_ack = (state == ST_HALTED);
  assign busy     = reset_n && (pipe_busy || ((state == ST_RUN) && (|req)));

endmodule
